// File: rtl/cdmesh_pkg.sv
// cdmesh_pkg: shared definitions for the CD-mesh request/reply protocol.
//   Header bit offsets for the fixed 64-bit flit layout and the helper that
//   builds a reply header from a buffered request.
//   Layout: [63]VC [62]Dx [61]Dy [60:56]Rsv [55:52]Hx [51:48]Hy
//           [47:40]SrcX [39:32]SrcY [31:0]payload
package cdmesh_pkg;

  localparam int HDR_W    = 64;
  localparam int VC_BIT   = 63;
  localparam int DX_BIT   = 62;
  localparam int DY_BIT   = 61;
  localparam int RSV_MSB  = 60;
  localparam int RSV_LSB  = 56;
  localparam int HX_MSB   = 55;
  localparam int HX_LSB   = 52;
  localparam int HY_MSB   = 51;
  localparam int HY_LSB   = 48;
  localparam int SRCX_MSB = 47;
  localparam int SRCX_LSB = 40;
  localparam int SRCY_MSB = 39;
  localparam int SRCY_LSB = 32;
  localparam int PAY_MSB  = 31;
  localparam int PAY_LSB  = 0;

  // Reply beat k of request req, routed back to the requester.
  // Rsv[60] flags the last beat, Rsv[59:56] carries the beat index.
  // Hop distance is computed at 8 bits and truncated to the 4-bit field.
  function automatic logic [HDR_W-1:0] mk_reply_hdr(
    input logic [HDR_W-1:0] req,
    input logic [3:0]       k,
    input logic             last,
    input logic [7:0]       my_x,
    input logic [7:0]       my_y
  );
    logic [HDR_W-1:0] hdr;
    logic [7:0]       sx;
    logic [7:0]       sy;
    logic [7:0]       hx;
    logic [7:0]       hy;
    logic             dx;
    logic             dy;
    sx  = req[SRCX_MSB:SRCX_LSB];
    sy  = req[SRCY_MSB:SRCY_LSB];
    dx  = (sx < my_x);
    dy  = (sy < my_y);
    hx  = dx ? (my_x - sx) : (sx - my_x);
    hy  = dy ? (my_y - sy) : (sy - my_y);
    hdr = '0;
    hdr[VC_BIT]              = req[VC_BIT];
    hdr[DX_BIT]              = dx;
    hdr[DY_BIT]              = dy;
    hdr[RSV_MSB]             = last;
    hdr[RSV_MSB-1:RSV_LSB]   = k;
    hdr[HX_MSB:HX_LSB]       = hx[3:0];
    hdr[HY_MSB:HY_LSB]       = hy[3:0];
    hdr[SRCX_MSB:SRCX_LSB]   = my_x;
    hdr[SRCY_MSB:SRCY_LSB]   = my_y;
    hdr[PAY_MSB:PAY_LSB]     = req[PAY_MSB:PAY_LSB] + {28'd0, k};
    return hdr;
  endfunction

endpackage

// File: rtl/llc_req_fifo.sv
// llc_req_fifo: DATA_W x FIFO_DEPTH synchronous request buffer.
//   Ports: clk, reset (async, active-high), push/push_data, pop/pop_data
//   (head is presented combinationally), full, empty, count (occupancy).
//   Pointers wrap naturally (FIFO_DEPTH is a power of two); the separate
//   count distinguishes full from empty. Push when full and pop when empty
//   are ignored. Storage is not reset.
module llc_req_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  import cdmesh_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/llc_reply_engine.sv
// llc_reply_engine: LLC proxy on a router local port. Buffers request
//   header flits and answers each with BURST reply flits routed back to the
//   requester, hop fields recomputed from this node's (MY_X, MY_Y).
//   Ports:
//     clk, reset      clock / async active-high reset
//     req_si/req_ri/req_di   request flit in (valid / ready / data)
//     rsp_so/rsp_ro/rsp_do   reply flit out (valid / ready / data)
//     req_cnt, rsp_cnt       accepted requests / sent reply flits (wrap)
//     busy                   FIFO non-empty or reply in flight
module llc_reply_engine #(
  parameter int DATA_W     = 64,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int BURST      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_si,
  output logic              req_ri,
  input  logic [DATA_W-1:0] req_di,
  output logic              rsp_so,
  input  logic              rsp_ro,
  output logic [DATA_W-1:0] rsp_do,
  output logic [CNT_W-1:0]  req_cnt,
  output logic [CNT_W-1:0]  rsp_cnt,
  output logic              busy
);
  import cdmesh_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);
  localparam logic [7:0] MYX       = 8'(MY_X);
  localparam logic [7:0] MYY       = 8'(MY_Y);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            state;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [AW:0]       count;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] req_p1;
  logic [3:0]        beat_p1;
  logic [3:0]        beat_nxt;
  logic              last_beat;
  logic              fire;

  // Ready is a pure function of occupancy: no push-through when full.
  assign req_ri    = !full;
  assign push      = req_si && !full;
  assign fire      = rsp_so && rsp_ro;
  assign last_beat = (beat_p1 == LAST_BEAT);
  assign beat_nxt  = beat_p1 + 4'd1;
  // Pop when idle, or when the last beat leaves so the next burst starts
  // on the same edge.
  assign pop       = !empty && ((state == S_IDLE) || (fire && last_beat));
  assign busy      = (count != '0) || rsp_so;

  llc_req_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (req_di),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Stage p1: request held for the remaining beats of its burst
  always_ff @(posedge clk) begin
    if (pop) req_p1 <= head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rsp_so  <= 1'b0;
      rsp_do  <= '0;
      beat_p1 <= '0;
      req_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      if (push) req_cnt <= req_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            beat_p1 <= '0;
            rsp_do  <= mk_reply_hdr(head, 4'd0, (LAST_BEAT == 4'd0), MYX, MYY);
            rsp_so  <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (fire) begin
            rsp_cnt <= rsp_cnt + 1'b1;
            if (!last_beat) begin
              beat_p1 <= beat_nxt;
              rsp_do  <= mk_reply_hdr(req_p1, beat_nxt, (beat_nxt == LAST_BEAT), MYX, MYY);
            end else if (!empty) begin
              beat_p1 <= '0;
              rsp_do  <= mk_reply_hdr(head, 4'd0, (LAST_BEAT == 4'd0), MYX, MYY);
            end else begin
              rsp_so  <= 1'b0;
              state   <= S_IDLE;
            end
          end
        end
        default: begin
          rsp_so <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
